// File: rtl/resp_checker.sv
// rtl/resp_checker.sv - response checker: delayed compare of DUT output against expected vectors
//
// Samples dut_out SETTLE cycles after each accepted stim_vld and compares it
// (4-state, so X/Z count as mismatches) with the exp value captured alongside
// the stimulus. Counts compared vectors and mismatches, then pulses done with
// a pass verdict.
//
// Optional feature macro: FIRST_FAIL_LOG_EN (adds the ff_* first-failure log).
//
// Parameters:
//   WIDTH   width of dut_out / exp
//   SETTLE  cycles from stim_vld to compare (0..7, 0 = same-cycle compare)
//   CNT_W   width of num_vec and both counters
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   begin a run (IDLE only)
//   num_vec   in   vectors in the run, latched on accepted start
//   stim_vld  in   stimulus applied this cycle, exp valid with it
//   exp       in   expected DUT output for this stimulus
//   dut_out   in   DUT output under check
//   busy      out  high in RUN and DRAIN
//   done      out  one-cycle end-of-run pulse
//   pass      out  no mismatches in the run, held until next accepted start
//   vec_cnt   out  vectors compared (saturating)
//   err_cnt   out  mismatches (saturating)
//   ff_vld/ff_idx/ff_got/ff_exp  out  first-failure log (FIRST_FAIL_LOG_EN only)

module resp_checker #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             stim_vld,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef FIRST_FAIL_LOG_EN
  ,
  output logic             ff_vld,
  output logic [CNT_W-1:0] ff_idx,
  output logic [WIDTH-1:0] ff_got,
  output logic [WIDTH-1:0] ff_exp
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] issue_cnt;
  logic             start_acc;
  logic             push;
  logic             cmp_vld;
  logic [WIDTH-1:0] cmp_exp;
  logic             pipe_busy;
  logic             mismatch;
  logic [CNT_W-1:0] vec_nx;
  logic [CNT_W-1:0] err_nx;

  assign start_acc = (state == IDLE) && start;
  assign push      = (state == RUN) && stim_vld;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  generate
    if (SETTLE == 0) begin : g_comb
      assign cmp_vld   = push;
      assign cmp_exp   = exp;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [SETTLE-1:0] v;
      logic [WIDTH-1:0]  d [SETTLE];

      always_ff @(posedge clk) begin
        if (rst) begin
          v <= '0;
          for (int i = 0; i < SETTLE; i++) d[i] <= '0;
        end else begin
          v[0] <= push;
          d[0] <= exp;
          for (int i = 1; i < SETTLE; i++) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
          end
        end
      end

      assign cmp_vld = v[SETTLE-1];
      assign cmp_exp = d[SETTLE-1];
      // Entries that will still be in flight after the current output-stage
      // compare; when none remain, the run can finish at this edge.
      if (SETTLE == 1) begin : g_one
        assign pipe_busy = 1'b0;
      end else begin : g_many
        assign pipe_busy = |v[SETTLE-2:0];
      end
    end
  endgenerate

  // 4-state compare so that X/Z on dut_out is flagged
  assign mismatch = cmp_vld && (dut_out !== cmp_exp);
  assign vec_nx   = (cmp_vld && (vec_cnt != '1)) ? vec_cnt + CNT_W'(1) : vec_cnt;
  assign err_nx   = (mismatch && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (num_vec == '0) ? DONE : RUN;
      RUN:     if (push && (issue_cnt == num_q - CNT_W'(1))) state_nx = DRAIN;
      DRAIN:   if (!pipe_busy) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      num_q     <= '0;
      issue_cnt <= '0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
      pass      <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_acc) begin
        num_q     <= num_vec;
        issue_cnt <= '0;
        vec_cnt   <= '0;
        err_cnt   <= '0;
        pass      <= (num_vec == '0);
      end else begin
        if (push) issue_cnt <= issue_cnt + CNT_W'(1);
        vec_cnt <= vec_nx;
        err_cnt <= err_nx;
        // The final compare may land on this same edge, so use err_nx.
        if ((state == DRAIN) && (state_nx == DONE)) pass <= (err_nx == '0);
      end
    end
  end

`ifdef FIRST_FAIL_LOG_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      ff_vld <= 1'b0;
      ff_idx <= '0;
      ff_got <= '0;
      ff_exp <= '0;
    end else if (mismatch && !ff_vld) begin
      ff_vld <= 1'b1;
      ff_idx <= vec_cnt;
      ff_got <= dut_out;
      ff_exp <= cmp_exp;
    end
  end
`endif

endmodule
